// File: rtl/writeback_buffer.sv
// Posted write-back buffer: absorbs evicted lines, coalesces repeat addresses,
// drains the oldest entry to ram on grant and forwards pending data to lookups.
module writeback_buffer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [ADDR_WIDTH-1:0]        push_addr,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic [ADDR_WIDTH-1:0]        lookup_addr,
  output logic                         lookup_hit,
  output logic [DATA_WIDTH-1:0]        lookup_data,
  input  logic                         mem_grant,
  output logic                         ram_we,
  output logic [ADDR_WIDTH-1:0]        ram_addr,
  output logic [DATA_WIDTH-1:0]        ram_wdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DEPTH-1:0]                 valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]                 count_q, count_d;
  logic                             ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0]            ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]            ram_wdata_q, ram_wdata_d;

  logic             drain_fire;
  logic             push_fire;
  logic             alloc;
  logic [DEPTH-1:0] match_vec;
  logic [DEPTH-1:0] lookup_vec;
  logic             match_any;
  logic [PTR_W-1:0] match_idx;

  assign drain_fire = (count_q != '0) && mem_grant;

  // The head entry leaving this cycle must not absorb a push; that push allocates instead.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign match_vec[gi]  = valid_q[gi] && (addr_q[gi] == push_addr) &&
                            !(drain_fire && (rd_ptr_q == PTR_W'(gi)));
    assign lookup_vec[gi] = valid_q[gi] && (addr_q[gi] == lookup_addr);
  end

  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match_vec[i]) begin
        match_any = 1'b1;
        match_idx = PTR_W'(i);
      end
    end
  end

  assign push_ready = (count_q < DEPTH_C) || match_any;
  assign push_fire  = push_valid && push_ready;
  assign alloc      = push_fire && !match_any;

  // Walk oldest to newest so a younger hit overrides the in-flight write and older entries.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx         = '0;
    lookup_hit  = ram_we_q && (ram_addr_q == lookup_addr);
    lookup_data = lookup_hit ? ram_wdata_q : '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if (lookup_vec[idx]) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[idx];
      end
    end
  end

  always_comb begin
    valid_d     = valid_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    if (drain_fire) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      ram_we_d          = 1'b1;
      ram_addr_d        = addr_q[rd_ptr_q];
      ram_wdata_d       = data_q[rd_ptr_q];
    end

    if (push_fire) begin
      if (match_any) begin
        data_d[match_idx] = push_data;
      end else begin
        valid_d[wr_ptr_q] = 1'b1;
        addr_d[wr_ptr_q]  = push_addr;
        data_d[wr_ptr_q]  = push_data;
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
    end

    case ({alloc, drain_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign count     = count_q;
  assign empty     = (count_q == '0) && !ram_we_q;

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: push, coalesce, drain order, full-buffer
// acceptance rules, forwarding priority and async reset mid-drain.
module tb_writeback_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [15:0] push_addr = '0;
  logic [31:0] push_data = '0;
  logic [15:0] lookup_addr = '0;
  logic        lookup_hit;
  logic [31:0] lookup_data;
  logic        mem_grant = 1'b0;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [2:0]  count;
  logic        empty;

  int checks = 0;
  int failures = 0;

  writeback_buffer #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_addr(push_addr), .push_data(push_data),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .mem_grant(mem_grant),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [31:0] d);
    push_valid = 1'b1;
    push_addr  = a;
    push_data  = d;
    #1;
    $display("push addr=0x%04h data=0x%08h ready=%0b grant=%0b", a, d, push_ready, mem_grant);
    tick();
    push_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  logic [15:0] exp_addr [4];
  logic [31:0] exp_data [4];

  initial begin
    exp_addr[0] = 16'h0010; exp_data[0] = 32'h1111_0010;
    exp_addr[1] = 16'h0020; exp_data[1] = 32'h0000_BEEF;
    exp_addr[2] = 16'h0030; exp_data[2] = 32'h3333_0030;
    exp_addr[3] = 16'h0040; exp_data[3] = 32'h4444_0040;

    // T1: reset state, single push held with no grant
    #3;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ready", push_ready, 1);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_hit", lookup_hit, 0);
    do_reset();
    push(16'h0010, 32'hAAAA_0001);
    lookup_addr = 16'h0010;
    #1;
    chk("t1_count", count, 1);
    chk("t1_hit", lookup_hit, 1);
    chk("t1_data", lookup_data, 32'hAAAA_0001);
    chk("t1_empty", empty, 0);

    // T2: drain; in-flight write still forwarded, then empty
    mem_grant = 1'b1;
    tick();
    $display("drain ram_we=%0b addr=0x%04h data=0x%08h", ram_we, ram_addr, ram_wdata);
    chk("t2_ram_we", ram_we, 1);
    chk("t2_ram_addr", ram_addr, 16'h0010);
    chk("t2_ram_wdata", ram_wdata, 32'hAAAA_0001);
    chk("t2_count", count, 0);
    chk("t2_inflight_hit", lookup_hit, 1);
    chk("t2_inflight_data", lookup_data, 32'hAAAA_0001);
    chk("t2_empty_busy", empty, 0);
    mem_grant = 1'b0;
    tick();
    chk("t2_ram_we_off", ram_we, 0);
    chk("t2_addr_hold", ram_addr, 16'h0010);
    chk("t2_empty", empty, 1);
    chk("t2_hit_gone", lookup_hit, 0);
    chk("t2_miss_data", lookup_data, 0);

    // T3: fill to DEPTH; new address refused, held address accepted
    push(16'h0010, 32'h1111_0010);
    push(16'h0020, 32'h2222_0020);
    push(16'h0030, 32'h3333_0030);
    push(16'h0040, 32'h4444_0040);
    chk("t3_count", count, 4);
    push_valid = 1'b1;
    push_addr  = 16'h0050;
    #1;
    chk("t3_ready_new", push_ready, 0);
    push_addr = 16'h0020;
    #1;
    chk("t3_ready_held", push_ready, 1);
    push_valid = 1'b0;

    // T4: coalesce into full buffer, then drain in FIFO order
    push(16'h0020, 32'h0000_BEEF);
    chk("t4_count", count, 4);
    lookup_addr = 16'h0020;
    #1;
    chk("t4_lookup_data", lookup_data, 32'h0000_BEEF);
    mem_grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      $display("drain ram_we=%0b addr=0x%04h data=0x%08h", ram_we, ram_addr, ram_wdata);
      chk($sformatf("t4_we%0d", i), ram_we, 1);
      chk($sformatf("t4_addr%0d", i), ram_addr, exp_addr[i]);
      chk($sformatf("t4_data%0d", i), ram_wdata, exp_data[i]);
    end
    chk("t4_count_end", count, 0);
    mem_grant = 1'b0;
    tick();
    chk("t4_empty", empty, 1);

    // T5: full with grant: new address and head address both refused; next cycle accepted
    push(16'h0010, 32'h5555_0010);
    push(16'h0020, 32'h5555_0020);
    push(16'h0030, 32'h5555_0030);
    push(16'h0040, 32'h5555_0040);
    mem_grant  = 1'b1;
    push_valid = 1'b1;
    push_addr  = 16'h0010;
    #1;
    chk("t5_ready_head", push_ready, 0);
    push_addr = 16'h0060;
    push_data = 32'h6666_0060;
    #1;
    chk("t5_ready_new", push_ready, 0);
    tick();
    chk("t5_count_after_drain", count, 3);
    chk("t5_drained_addr", ram_addr, 16'h0010);
    mem_grant = 1'b0;
    #1;
    chk("t5_ready_next", push_ready, 1);
    tick();
    push_valid = 1'b0;
    chk("t5_count", count, 4);

    // T6: async reset with ram_we high and 3 entries left
    mem_grant = 1'b1;
    tick();
    mem_grant = 1'b0;
    chk("t6_pre_we", ram_we, 1);
    chk("t6_pre_count", count, 3);
    lookup_addr = 16'h0030;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_ram_we", ram_we, 0);
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_hit", lookup_hit, 0);
    chk("t6_ready", push_ready, 1);
    rst = 1'b0;
    tick();

    // Head match during drain allocates; newest entry beats in-flight write
    push(16'h0070, 32'h0000_0001);
    mem_grant = 1'b1;
    push_valid = 1'b1;
    push_addr  = 16'h0070;
    push_data  = 32'h0000_0002;
    #1;
    chk("t7_ready", push_ready, 1);
    tick();
    push_valid = 1'b0;
    mem_grant  = 1'b0;
    lookup_addr = 16'h0070;
    #1;
    chk("t7_ram_wdata", ram_wdata, 32'h0000_0001);
    chk("t7_count", count, 1);
    chk("t7_hit", lookup_hit, 1);
    chk("t7_newest", lookup_data, 32'h0000_0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
